// File: rtl/reorder_buffer_if.sv
// Decode / execute / commit bundle between the pipeline and the reorder buffer.
// The slave side is the buffer itself; the master side allocates and completes entries.
interface reorder_buffer_if #(
   parameter int NUM_ENTRIES = 8,
   parameter int TAG_W       = $clog2(NUM_ENTRIES),
   parameter int ADDR_W      = 5,
   parameter int DATA_W      = 32,
   parameter int PC_W        = 32,
   parameter int XADDR_W     = 32,
   parameter int XTYPE_W     = 3
);
   logic               alloc_valid;
   logic               alloc_ready;
   logic [TAG_W-1:0]   alloc_tag;
   logic               alloc_has_dest;
   logic [ADDR_W-1:0]  alloc_dest;
   logic [PC_W-1:0]    alloc_pc;
   logic               alloc_iret;

   logic               complete_valid;
   logic [TAG_W-1:0]   complete_tag;
   logic [DATA_W-1:0]  complete_data;
   logic               complete_xcpt;
   logic [XTYPE_W-1:0] complete_xcpt_type;
   logic [XADDR_W-1:0] complete_xcpt_addr;

   logic               writeEn;
   logic [ADDR_W-1:0]  dest_addr;
   logic [DATA_W-1:0]  writeVal;
   logic               xcpt_valid;
   logic [XTYPE_W-1:0] xcpt_type;
   logic [PC_W-1:0]    rmPC;
   logic [XADDR_W-1:0] rmAddr;
   logic               iret_instr;
   logic               flush;
   logic               empty;

   modport slave (
      input  alloc_valid, alloc_has_dest, alloc_dest, alloc_pc, alloc_iret,
      input  complete_valid, complete_tag, complete_data, complete_xcpt,
      input  complete_xcpt_type, complete_xcpt_addr,
      output alloc_ready, alloc_tag,
      output writeEn, dest_addr, writeVal, xcpt_valid, xcpt_type, rmPC, rmAddr,
      output iret_instr, flush, empty
   );

   modport master (
      output alloc_valid, alloc_has_dest, alloc_dest, alloc_pc, alloc_iret,
      output complete_valid, complete_tag, complete_data, complete_xcpt,
      output complete_xcpt_type, complete_xcpt_addr,
      input  alloc_ready, alloc_tag,
      input  writeEn, dest_addr, writeVal, xcpt_valid, xcpt_type, rmPC, rmAddr,
      input  iret_instr, flush, empty
   );
endinterface

// File: rtl/reorder_buffer.sv
// In-order commit buffer: entries allocated in program order, completed out of order
// by tag, retired one per cycle from head; a committed exception flushes everything.
module reorder_buffer #(
   parameter int NUM_ENTRIES = 8,
   parameter int ADDR_W      = 5,
   parameter int DATA_W      = 32,
   parameter int PC_W        = 32,
   parameter int XADDR_W     = 32,
   parameter int XTYPE_W     = 3
) (
   input  logic              clock,
   input  logic              reset,
   reorder_buffer_if.slave   rob
);
   localparam int TAG_W = $clog2(NUM_ENTRIES);

   logic [NUM_ENTRIES-1:0] valid_reg, valid_next;
   logic [NUM_ENTRIES-1:0] done_reg, done_next;
   logic [NUM_ENTRIES-1:0] has_dest_reg, iret_reg, xcpt_reg;
   logic [ADDR_W-1:0]      dest_reg  [NUM_ENTRIES];
   logic [PC_W-1:0]        pc_reg    [NUM_ENTRIES];
   logic [DATA_W-1:0]      data_reg  [NUM_ENTRIES];
   logic [XTYPE_W-1:0]     xtype_reg [NUM_ENTRIES];
   logic [XADDR_W-1:0]     xaddr_reg [NUM_ENTRIES];

   logic [TAG_W:0]   head_reg, head_next, tail_reg, tail_next;
   logic [TAG_W-1:0] head_idx, tail_idx;
   logic             full_reg, full_next;
   logic             commit, commit_ok, commit_xcpt;
   logic             alloc_ready, alloc_fire, complete_fire;

   assign head_idx = head_reg[TAG_W-1:0];
   assign tail_idx = tail_reg[TAG_W-1:0];

   // Commit is gated by reset so nothing retires in a reset cycle.
   always_comb begin
      commit        = !reset && valid_reg[head_idx] && done_reg[head_idx];
      commit_xcpt   = commit && xcpt_reg[head_idx];
      commit_ok     = commit && !xcpt_reg[head_idx];
      alloc_ready   = !reset && !full_reg && !commit_xcpt;
      alloc_fire    = rob.alloc_valid && alloc_ready;
      complete_fire = rob.complete_valid && valid_reg[rob.complete_tag]
                      && !done_reg[rob.complete_tag] && !commit_xcpt;
      head_next     = head_reg + {{TAG_W{1'b0}}, commit_ok};
      tail_next     = tail_reg + {{TAG_W{1'b0}}, alloc_fire};
      full_next     = (head_next[TAG_W-1:0] == tail_next[TAG_W-1:0])
                      && (head_next[TAG_W] != tail_next[TAG_W]);
   end

   generate
      for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
         logic alloc_hit, commit_hit, complete_hit;
         assign alloc_hit    = alloc_fire && (tail_idx == TAG_W'(gi));
         assign commit_hit   = commit_ok && (head_idx == TAG_W'(gi));
         assign complete_hit = complete_fire && (rob.complete_tag == TAG_W'(gi));
         assign valid_next[gi] = alloc_hit ? 1'b1 : (commit_hit ? 1'b0 : valid_reg[gi]);
         assign done_next[gi]  = alloc_hit ? 1'b0 : (complete_hit ? 1'b1 : done_reg[gi]);
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset || commit_xcpt) begin
         valid_reg <= '0;
         done_reg  <= '0;
         head_reg  <= '0;
         tail_reg  <= '0;
         full_reg  <= 1'b0;
      end else begin
         valid_reg <= valid_next;
         done_reg  <= done_next;
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         full_reg  <= full_next;
      end
   end

   // Payload needs no reset: it is only observed behind valid && done.
   always_ff @(posedge clock) begin
      if (alloc_fire) begin
         has_dest_reg[tail_idx] <= rob.alloc_has_dest;
         dest_reg[tail_idx]     <= rob.alloc_dest;
         pc_reg[tail_idx]       <= rob.alloc_pc;
         iret_reg[tail_idx]     <= rob.alloc_iret;
      end
      if (complete_fire) begin
         data_reg[rob.complete_tag]  <= rob.complete_data;
         xcpt_reg[rob.complete_tag]  <= rob.complete_xcpt;
         xtype_reg[rob.complete_tag] <= rob.complete_xcpt_type;
         xaddr_reg[rob.complete_tag] <= rob.complete_xcpt_addr;
      end
   end

   always_comb begin
      rob.alloc_ready = alloc_ready;
      rob.alloc_tag   = tail_idx;
      rob.empty       = (head_reg == tail_reg);
      rob.writeEn     = commit_ok && has_dest_reg[head_idx];
      rob.dest_addr   = commit_ok ? dest_reg[head_idx] : '0;
      rob.writeVal    = commit_ok ? data_reg[head_idx] : '0;
      rob.iret_instr  = commit_ok && iret_reg[head_idx];
      rob.xcpt_valid  = commit_xcpt;
      rob.flush       = commit_xcpt;
      rob.xcpt_type   = commit_xcpt ? xtype_reg[head_idx] : '0;
      rob.rmPC        = commit_xcpt ? pc_reg[head_idx] : '0;
      rob.rmAddr      = commit_xcpt ? xaddr_reg[head_idx] : '0;
   end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed vector table, hand-written corner sequences and a randomized run
// checked against a queue-based program-order model of the reorder buffer.
module tb_reorder_buffer;
   localparam int N = 8;

   logic clock = 1'b0;
   logic reset = 1'b1;

   reorder_buffer_if #(.NUM_ENTRIES(N)) bus ();
   reorder_buffer #(.NUM_ENTRIES(N)) dut (.clock(clock), .reset(reset), .rob(bus));

   always #5 clock = ~clock;

   typedef struct packed {
      logic rst, av, hd; logic [4:0] dst; logic [31:0] pc; logic ir, cv;
      logic [2:0] ct; logic [31:0] cd; logic cx; logic [2:0] cxt; logic [31:0] cxa;
   } in_t;
   typedef struct packed {
      logic ready; logic [2:0] tag; logic we; logic [4:0] dest; logic [31:0] val;
      logic xv; logic [2:0] xt; logic [31:0] rmpc, rmaddr; logic iret, empty;
   } exp_t;
   typedef struct packed { in_t i; exp_t e; } vec_t;
   typedef struct {
      int tag; logic hd; logic [4:0] dst; logic [31:0] pc; logic ir;
      bit done; logic [31:0] data; bit x; logic [2:0] xt; logic [31:0] xa;
   } ent_t;

   int   n_cmp = 0, n_bad = 0;
   vec_t vt[$];
   ent_t q[$];
   int   next_tag = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic check_out(string ctx, exp_t e, logic rst);
      if (!rst) begin
         chk({ctx, " alloc_ready"}, 64'(bus.alloc_ready), 64'(e.ready));
         if (e.ready) chk({ctx, " alloc_tag"}, 64'(bus.alloc_tag), 64'(e.tag));
         chk({ctx, " empty"}, 64'(bus.empty), 64'(e.empty));
      end
      chk({ctx, " writeEn"},    64'(bus.writeEn),    64'(e.we));
      chk({ctx, " dest_addr"},  64'(bus.dest_addr),  64'(e.dest));
      chk({ctx, " writeVal"},   64'(bus.writeVal),   64'(e.val));
      chk({ctx, " xcpt_valid"}, 64'(bus.xcpt_valid), 64'(e.xv));
      chk({ctx, " flush"},      64'(bus.flush),      64'(e.xv));
      chk({ctx, " xcpt_type"},  64'(bus.xcpt_type),  64'(e.xt));
      chk({ctx, " rmPC"},       64'(bus.rmPC),       64'(e.rmpc));
      chk({ctx, " rmAddr"},     64'(bus.rmAddr),     64'(e.rmaddr));
      chk({ctx, " iret_instr"}, 64'(bus.iret_instr), 64'(e.iret));
   endtask

   task automatic drive(in_t i);
      reset                  = i.rst;
      bus.alloc_valid        = i.av;
      bus.alloc_has_dest     = i.hd;
      bus.alloc_dest         = i.dst;
      bus.alloc_pc           = i.pc;
      bus.alloc_iret         = i.ir;
      bus.complete_valid     = i.cv;
      bus.complete_tag       = i.ct;
      bus.complete_data      = i.cd;
      bus.complete_xcpt      = i.cx;
      bus.complete_xcpt_type = i.cxt;
      bus.complete_xcpt_addr = i.cxa;
   endtask

   task automatic cycle(string ctx, in_t i, exp_t e);
      drive(i);
      @(negedge clock);
      check_out(ctx, e, i.rst);
      @(posedge clock);
      #1;
   endtask

   function automatic in_t idle();
      in_t r = '0;
      return r;
   endfunction

   function automatic in_t rst_in();
      in_t r = '0;
      r.rst = 1'b1;
      return r;
   endfunction

   function automatic in_t al(in_t b, logic hd, logic [4:0] dst, logic [31:0] pc, logic ir);
      b.av = 1'b1; b.hd = hd; b.dst = dst; b.pc = pc; b.ir = ir;
      return b;
   endfunction

   function automatic in_t cp(in_t b, int tag, logic [31:0] d, logic x = 1'b0,
                              logic [2:0] xt = 3'd0, logic [31:0] xa = 32'd0);
      b.cv = 1'b1; b.ct = 3'(tag); b.cd = d; b.cx = x; b.cxt = xt; b.cxa = xa;
      return b;
   endfunction

   function automatic exp_t ex(logic ready, int tag, logic empty);
      exp_t r = '0;
      r.ready = ready; r.tag = 3'(tag); r.empty = empty;
      return r;
   endfunction

   function automatic exp_t wr(exp_t b, logic we, logic [4:0] dest, logic [31:0] val,
                               logic ir = 1'b0);
      b.we = we; b.dest = dest; b.val = val; b.iret = ir;
      return b;
   endfunction

   function automatic exp_t xc(exp_t b, logic [2:0] t, logic [31:0] pc, logic [31:0] addr);
      b.xv = 1'b1; b.xt = t; b.rmpc = pc; b.rmaddr = addr;
      return b;
   endfunction

   function automatic void add(in_t i, exp_t e);
      vec_t v;
      v.i = i;
      v.e = e;
      vt.push_back(v);
   endfunction

   // Program-order model: the queue front is the oldest instruction.
   function automatic exp_t model_exp(logic rst);
      exp_t r = '0;
      if (!rst && q.size() > 0 && q[0].done) begin
         if (q[0].x) begin
            r.xv = 1'b1; r.xt = q[0].xt; r.rmpc = q[0].pc; r.rmaddr = q[0].xa;
         end else begin
            r.we = q[0].hd; r.dest = q[0].dst; r.val = q[0].data; r.iret = q[0].ir;
         end
      end
      r.ready = !rst && (q.size() < N) && !r.xv;
      r.tag   = 3'(next_tag);
      r.empty = (q.size() == 0);
      return r;
   endfunction

   function automatic void model_step(in_t i, exp_t e);
      bit   retire;
      ent_t n;
      if (i.rst || e.xv) begin
         q.delete();
         next_tag = 0;
         return;
      end
      retire = (q.size() > 0) && q[0].done;
      if (i.cv) begin
         foreach (q[k]) begin
            if (q[k].tag == int'(i.ct) && !q[k].done) begin
               q[k].done = 1'b1; q[k].data = i.cd; q[k].x = i.cx;
               q[k].xt = i.cxt; q[k].xa = i.cxa;
            end
         end
      end
      if (retire) void'(q.pop_front());
      if (i.av && e.ready) begin
         n = '{tag: next_tag, hd: i.hd, dst: i.dst, pc: i.pc, ir: i.ir,
               done: 1'b0, data: 32'd0, x: 1'b0, xt: 3'd0, xa: 32'd0};
         q.push_back(n);
         next_tag = (next_tag + 1) % N;
      end
   endfunction

   initial begin
      // In-order writes with overlapping alloc/complete.
      add(rst_in(), ex(0, 0, 0));
      add(al(idle(), 1, 1, 'h100, 0), ex(1, 0, 1));
      add(cp(al(idle(), 1, 2, 'h104, 0), 0, 'h11), ex(1, 1, 0));
      add(cp(al(idle(), 1, 3, 'h108, 0), 1, 'h22), wr(ex(1, 2, 0), 1, 1, 'h11));
      add(cp(idle(), 2, 'h33), wr(ex(1, 3, 0), 1, 2, 'h22));
      add(idle(), wr(ex(1, 3, 0), 1, 3, 'h33));
      add(idle(), ex(1, 3, 1));
      // Exception on tag 1: flush, younger completions and allocs discarded.
      add(rst_in(), ex(0, 0, 0));
      add(al(idle(), 1, 1, 'h100, 0), ex(1, 0, 1));
      add(cp(al(idle(), 1, 2, 'h104, 0), 0, 'hA0), ex(1, 1, 0));
      add(cp(al(idle(), 1, 3, 'h108, 0), 1, 'h0, 1, 2, 'hBEEF), wr(ex(1, 2, 0), 1, 1, 'hA0));
      add(cp(al(idle(), 1, 4, 'h10C, 0), 2, 'hC2), xc(ex(0, 3, 0), 2, 'h104, 'hBEEF));
      add(cp(idle(), 3, 'hD3), ex(1, 0, 1));
      add(cp(idle(), 2, 'hC2), ex(1, 0, 1));
      add(idle(), ex(1, 0, 1));
      // iret without destination.
      add(rst_in(), ex(0, 0, 0));
      add(al(idle(), 0, 0, 'h200, 1), ex(1, 0, 1));
      add(cp(idle(), 0, 'h55), ex(1, 1, 0));
      add(idle(), wr(ex(1, 1, 0), 0, 0, 'h55, 1));
      add(idle(), ex(1, 1, 1));

      drive(rst_in());
      @(posedge clock);
      #1;
      for (int k = 0; k < vt.size(); k++) begin
         cycle($sformatf("vec%0d", k), vt[k].i, vt[k].e);
         $display("vec %0d applied", k);
      end

      // Out-of-order completion: nothing retires until tag 0 is done.
      cycle("ooo", rst_in(), ex(0, 0, 0));
      for (int k = 0; k < 3; k++)
         cycle($sformatf("ooo_alloc%0d", k), al(idle(), 1, 5'(k + 1), 32'('h300 + 4 * k), 0),
               ex(1, k, k == 0));
      cycle("ooo_c2", cp(idle(), 2, 'hC), ex(1, 3, 0));
      cycle("ooo_c1", cp(idle(), 1, 'hB), ex(1, 3, 0));
      cycle("ooo_c0", cp(idle(), 0, 'hA), ex(1, 3, 0));
      cycle("ooo_w0", idle(), wr(ex(1, 3, 0), 1, 1, 'hA));
      cycle("ooo_w1", idle(), wr(ex(1, 3, 0), 1, 2, 'hB));
      cycle("ooo_w2", idle(), wr(ex(1, 3, 0), 1, 3, 'hC));
      cycle("ooo_end", idle(), ex(1, 3, 1));
      $display("seq out-of-order done");

      // Fill all entries, free one slot, wrap the tail.
      cycle("fill", rst_in(), ex(0, 0, 0));
      for (int k = 0; k < N; k++)
         cycle($sformatf("fill_alloc%0d", k), al(idle(), 1, 5'(k + 1), 32'('h400 + 4 * k), 0),
               ex(1, k, k == 0));
      cycle("fill_full", idle(), ex(0, 0, 0));
      cycle("fill_c0", cp(idle(), 0, 'h77), ex(0, 0, 0));
      cycle("fill_w0", idle(), wr(ex(0, 0, 0), 1, 1, 'h77));
      cycle("fill_wrap", al(idle(), 1, 9, 'h500, 0), ex(1, 0, 0));
      cycle("fill_full2", idle(), ex(0, 1, 0));
      $display("seq fill done");

      // Reset with 5 pending (head done): no retire in the reset cycle.
      cycle("mrst", rst_in(), ex(0, 0, 0));
      for (int k = 0; k < 5; k++)
         cycle($sformatf("mrst_alloc%0d", k), al(idle(), 1, 5'(k + 1), 32'('h600 + 4 * k), 0),
               ex(1, k, k == 0));
      cycle("mrst_c1", cp(idle(), 1, 'h21), ex(1, 5, 0));
      cycle("mrst_c0", cp(idle(), 0, 'h20), ex(1, 5, 0));
      cycle("mrst_reset", rst_in(), ex(0, 0, 0));
      cycle("mrst_post0", idle(), ex(1, 0, 1));
      cycle("mrst_post1", idle(), ex(1, 0, 1));
      $display("seq mid-reset done");

      // Randomized run against the model.
      cycle("rnd_reset", rst_in(), ex(0, 0, 0));
      q.delete();
      next_tag = 0;
      for (int c = 0; c < 1500; c++) begin
         in_t  i;
         exp_t e;
         int   pend[$];
         i     = '0;
         i.av  = ($urandom_range(3) != 0);
         i.hd  = 1'($urandom_range(1));
         i.dst = 5'($urandom);
         i.pc  = $urandom;
         i.ir  = ($urandom_range(7) == 0);
         foreach (q[k]) if (!q[k].done) pend.push_back(q[k].tag);
         if (pend.size() > 0 && $urandom_range(2) != 0) begin
            i.cv = 1'b1;
            i.ct = 3'(pend[$urandom_range(pend.size() - 1)]);
         end else if ($urandom_range(7) == 0) begin
            i.cv = 1'b1;
            i.ct = 3'($urandom);
         end
         i.cd  = $urandom;
         i.cx  = ($urandom_range(15) == 0);
         i.cxt = 3'($urandom);
         i.cxa = $urandom;
         i.rst = ($urandom_range(199) == 0);
         e = model_exp(i.rst);
         cycle($sformatf("rnd%0d", c), i, e);
         if (e.we || e.xv || e.iret)
            $display("rnd %0d commit we=%0d dest=%0d val=%h xcpt=%0d iret=%0d",
                     c, e.we, e.dest, e.val, e.xv, e.iret);
         model_step(i, e);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order commit buffer between the execute/memory stages and `regFile`. Decode allocates one entry per instruction; execution units report completion out of order by tag; the block retires entries strictly in program order, one per cycle. It drives `regFile`'s write port, exception inputs (`xcpt_valid`, `xcpt_type`, `rmPC`, `rmAddr`) and `iret_instr`, and flushes the pipeline on a committed exception.

## Interface
- `NUM_ENTRIES`, 8: buffer depth; power of two, ≥2.
- `TAG_W`, $clog2(NUM_ENTRIES): entry tag width.

- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clock`.
- `alloc_valid`  in  1  decode requests an entry.
- `alloc_ready`  out  1  entry available this cycle.
- `alloc_tag`  out  TAG_W  tag assigned to the accepted request (equals the tail index).
- `alloc_has_dest`  in  1  instruction writes a register.
- `alloc_dest`  in  `REG_FILE_ADDR_RANGE`  destination register.
- `alloc_pc`  in  `PC_WIDTH`  instruction PC.
- `alloc_iret`  in  1  instruction is `iret`.
- `complete_valid`  in  1  an execution unit finished an entry.
- `complete_tag`  in  TAG_W  finished entry.
- `complete_data`  in  `REG_FILE_DATA_RANGE`  result value.
- `complete_xcpt`  in  1  instruction faulted.
- `complete_xcpt_type`  in  xcpt_type_t  fault cause.
- `complete_xcpt_addr`  in  `REG_FILE_XCPT_ADDR_RANGE`  faulting address.
- `writeEn`  out  1  to `regFile`: commit write.
- `dest_addr`  out  `REG_FILE_ADDR_RANGE`  to `regFile`.
- `writeVal`  out  `REG_FILE_DATA_RANGE`  to `regFile`.
- `xcpt_valid`  out  1  to `regFile`: committed exception.
- `xcpt_type`  out  xcpt_type_t  to `regFile`.
- `rmPC`  out  `PC_WIDTH`  to `regFile`: PC of the faulting instruction.
- `rmAddr`  out  `REG_FILE_XCPT_ADDR_RANGE`  to `regFile`.
- `iret_instr`  out  1  to `regFile`: committed `iret`.
- `flush`  out  1  kill all younger in-flight work (same cycle as `xcpt_valid`).
- `empty`  out  1  no valid entries.

## Operation
- Per-entry state, registered: valid, done, has_dest, dest, pc, iret, data, xcpt, xcpt_type, xcpt_addr.
- Pointers `head_ff`, `tail_ff`: TAG_W+1 bits each; the MSB is a wrap bit.
  - Full when the indices are equal and the wrap bits differ.
  - Empty when the pointers are equal.
- Allocate when `alloc_valid && alloc_ready`.
  - `alloc_ready = !full_ff && !flush`.
  - Write the entry at tail with done=0, then increment tail.
- Completion: if `complete_valid` and entry[`complete_tag`] is valid and not done:
  - set done;
  - store data, xcpt, xcpt_type and xcpt_addr.
  - Completion to an invalid or already-done entry is ignored; no state change.
- Commit condition: head entry valid && done. Commit outputs are combinational from registered head state. One commit per cycle. Three cases:
  - **No xcpt:**
    - `writeEn` = has_dest; `dest_addr` = dest; `writeVal` = data.
    - `iret_instr` = iret.
    - Invalidate the head entry and increment head.
  - **xcpt:**
    - `xcpt_valid`=1, `xcpt_type`, `rmPC`=pc, `rmAddr`=xcpt_addr; `flush`=1.
    - `writeEn`=0, `iret_instr`=0.
    - Next cycle: all entries invalid, head=tail=0 (both wrap bits 0), `empty`=1.
  - **No commit:** all commit outputs are 0, including the data buses.
- Simultaneous events:
  - Alloc and commit in the same cycle are both performed. The count is unchanged.
  - Completion and commit of the same entry in the same cycle cannot happen (commit requires a registered done).
  - Completion in the flush cycle is discarded.
  - An alloc request in the flush cycle is not accepted.

## Timing
- Reset (synchronous): all entries invalid, pointers 0, outputs 0. `alloc_ready`=1 and `empty`=1 from the first cycle after reset release.
- Reset asserted mid-operation discards all entries. No commit outputs are asserted in the reset cycle.
- Alloc→earliest commit: an entry allocated in cycle N and completed in cycle N+1 commits in cycle N+2.
- Completion→commit latency: 1 cycle when the completed entry is at head.
- `alloc_tag` is valid in the same cycle as `alloc_ready`.
- `full_ff` is registered; a commit in the same cycle does not free a slot for allocation in that cycle.
- Throughput: 1 alloc and 1 commit per cycle.

## Test plan
- **Reset then 3 allocs with dest r1, r2, r3; complete tags 0, 1, 2 with 0x11, 0x22, 0x33 in consecutive cycles** → `writeEn` pulses in 3 consecutive cycles with (1,0x11), (2,0x22), (3,0x33); then `empty`=1.
- **Out-of-order completion: alloc tags 0–2; complete 2, then 1, then 0** → no commit until tag 0 completes; then 3 commits on 3 consecutive cycles in order 0, 1, 2.
- **Fill all 8 entries** → `alloc_ready`=0 on the cycle after the 8th accept. Complete tag 0 → commit; `alloc_ready`=1 the cycle after. Next `alloc_tag`=0 (wrap-around).
- **Alloc tags 0–3 with pc 0x100–0x10C; tag 1 completes with xcpt type 2, addr 0xBEEF; others complete normally** → tag 0 writes. Then a single cycle with `xcpt_valid`=1, `rmPC`=0x104, `rmAddr`=0xBEEF, `xcpt_type`=2, `flush`=1, `writeEn`=0. Next cycle `empty`=1; tags 2–3 are never written.
- **Alloc an `iret` entry without dest and complete it** → one cycle with `iret_instr`=1 and `writeEn`=0.
- **Assert reset with 5 entries pending, 2 of them done** → no commit occurs; after release `empty`=1 and `alloc_tag`=0.
